// File: rtl/serial_feeder_pkg.sv
// Shared definitions for the serial feeder: state encoding, idle-bit default and
// the bit-counter sizing helper.
package serial_feeder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic IDLE_BIT_DEF = 1'b0;

    // Width needed to count 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_feeder_bit_counter.sv
// Bit-position counter for the feeder: clears on a new word or flush, increments
// while shifting, saturates at WIDTH-1 and flags the terminal count.
module feeder_bit_counter
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/serial_feeder.sv
// Parallel-to-serial feeder: accepts WIDTH-bit words on valid/ready and drives
// them one bit per clock onto x, streaming back-to-back words without a gap.
module serial_feeder
    import serial_feeder_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = IDLE_BIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             word_done
);

    state_t           state_p0;
    logic [WIDTH-1:0] shift_p0;
    logic             last;
    logic             accept;
    logic             cnt_clear;
    logic             cnt_inc;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // Ready depends only on state and abort so a new word can chain onto the last bit.
    assign din_ready = !abort && ((state_p0 == IDLE) || ((state_p0 == SHIFT) && last));
    assign accept    = din_valid && din_ready;
    assign cnt_clear = accept || ((state_p0 == SHIFT) && (abort || last));
    assign cnt_inc   = (state_p0 == SHIFT) && !abort;
    assign word_done = x_valid && last;

    feeder_bit_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clear(cnt_clear),
        .inc  (cnt_inc),
        .tc   (last)
    );

    // Stage p0: FSM, shift register and registered serial outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_p0 <= IDLE;
            shift_p0 <= '0;
            x        <= IDLE_BIT;
            x_valid  <= 1'b0;
        end else if ((state_p0 == SHIFT) && abort) begin
            state_p0 <= IDLE;
            x        <= IDLE_BIT;
            x_valid  <= 1'b0;
        end else if (accept) begin
            state_p0 <= SHIFT;
            shift_p0 <= advance(din);
            x        <= head_bit(din);
            x_valid  <= 1'b1;
        end else if (state_p0 == SHIFT) begin
            if (last) begin
                state_p0 <= IDLE;
                x        <= IDLE_BIT;
                x_valid  <= 1'b0;
            end else begin
                shift_p0 <= advance(shift_p0);
                x        <= head_bit(shift_p0);
            end
        end
    end

endmodule

// File: tb/tb_serial_feeder.sv
// Bench for serial_feeder: an MSB-first and an LSB-first instance checked cycle by
// cycle against a word/bit-position reference model and a "1011" detector model.
module tb_serial_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       abort = 1'b0;
    logic       vm = 1'b0;
    logic       vl = 1'b0;
    logic [7:0] din = 8'h00;
    logic       rdy_m, x_m, xv_m, wd_m;
    logic       rdy_l, x_l, xv_l, wd_l;

    int checks = 0;
    int passed = 0;

    // Reference model: per instance, is a word in flight, which word, which bit is on x.
    bit         m_act [2];
    int         m_pos [2];
    logic [7:0] m_word[2];

    always #5 clk = ~clk;

    serial_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(vm), .din_ready(rdy_m),
        .abort(abort), .x(x_m), .x_valid(xv_m), .word_done(wd_m)
    );

    serial_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(vl), .din_ready(rdy_l),
        .abort(abort), .x(x_l), .x_valid(xv_l), .word_done(wd_l)
    );

    // Expected {x, x_valid, word_done, din_ready} for instance d (0 = MSB-first).
    function automatic logic [3:0] expv(input int d);
        logic b;
        b = 1'b0;
        if (m_act[d]) b = (d == 0) ? m_word[d][7 - m_pos[d]] : m_word[d][m_pos[d]];
        return {b, m_act[d], m_act[d] && (m_pos[d] == 7), (!m_act[d] || (m_pos[d] == 7)) && !abort};
    endfunction

    function automatic logic [3:0] obs(input int d);
        return (d == 0) ? {x_m, xv_m, wd_m, rdy_m} : {x_l, xv_l, wd_l, rdy_l};
    endfunction

    // Advance the reference model across one rising edge, then settle 1 time unit.
    task automatic tick();
        logic v;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            v = (d == 0) ? vm : vl;
            if (!rst || abort) begin
                m_act[d] = 1'b0;
            end else if (v && (!m_act[d] || m_pos[d] == 7)) begin
                m_act[d]  = 1'b1;
                m_word[d] = din;
                m_pos[d]  = 0;
            end else if (m_act[d]) begin
                if (m_pos[d] == 7) m_act[d] = 1'b0;
                else m_pos[d]++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; vm = 1'b1; vl = 1'b1; din = 8'hB2;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs(d) !== 4'b0001) $display("FAIL reset d%0d c%0d: x/xv/wd/rdy got %b want 0001", d, c, obs(d));
                else passed++;
            end
        end
        @(negedge clk);
        rst = 1'b1; vm = 1'b0; vl = 1'b0;
        m_act[0] = 1'b0; m_act[1] = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs(d) !== 4'b0001) $display("FAIL reset_release d%0d: got %b want 0001", d, obs(d));
            else passed++;
        end
    endtask

    task automatic test_msb_word();
        logic [3:0] hist = 4'b0;
        logic [7:0] got = 8'h00;
        int fires = 0, fcyc = -1;
        din = 8'hB2; vm = 1'b1;
        tick();
        vm = 1'b0; din = 8'h00;
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (obs(0) !== expv(0)) $display("FAIL msb_b2 c%0d: got %b want %b", c, obs(0), expv(0));
            else passed++;
            if (c <= 8) got = {got[6:0], x_m};
            hist = {hist[2:0], x_m};
            if (hist == 4'b1011) begin fires++; fcyc = c + 1; end
            tick();
        end
        checks++;
        if (got !== 8'hB2) $display("FAIL msb_b2_stream: got %h want b2", got); else passed++;
        checks++;
        if (fires != 1 || fcyc != 5) $display("FAIL msb_b2_detect: fires %0d at %0d want 1 at 5", fires, fcyc);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  hist = 4'b0;
        logic [15:0] got = 16'h0;
        int vcount = 0, fires = 0, wdmask = 0;
        din = 8'h0B; vm = 1'b1;
        tick();
        for (int c = 1; c <= 18; c++) begin
            checks++;
            if (obs(0) !== expv(0)) $display("FAIL b2b c%0d: got %b want %b", c, obs(0), expv(0));
            else passed++;
            if (c <= 16) begin got = {got[14:0], x_m}; vcount += int'(xv_m); end
            if (wd_m) wdmask |= (1 << c);
            hist = {hist[2:0], x_m};
            if (hist == 4'b1011) fires++;
            if (c == 1) din = 8'hB0;
            if (c == 9) vm = 1'b0;
            tick();
        end
        checks++;
        if (got !== 16'h0BB0 || vcount != 16) $display("FAIL b2b_stream: got %h valid %0d want 0bb0 valid 16", got, vcount);
        else passed++;
        checks++;
        if (wdmask != ((1 << 8) | (1 << 16))) $display("FAIL b2b_word_done: got mask %h want %h", wdmask, (1 << 8) | (1 << 16));
        else passed++;
        checks++;
        if (fires != 2) $display("FAIL b2b_detect: got %0d want 2", fires); else passed++;
    endtask

    task automatic test_lsb_word();
        logic [3:0] hist = 4'b0;
        logic [7:0] got = 8'h00;
        int fires = 0;
        din = 8'h0D; vl = 1'b1;
        tick();
        vl = 1'b0; din = 8'hFF;
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (obs(1) !== expv(1)) $display("FAIL lsb_0d c%0d: got %b want %b", c, obs(1), expv(1));
            else passed++;
            if (c <= 8) got = {got[6:0], x_l};
            hist = {hist[2:0], x_l};
            if (hist == 4'b1011) fires++;
            tick();
        end
        checks++;
        if (got !== 8'hB0) $display("FAIL lsb_0d_stream: got %h want b0", got); else passed++;
        checks++;
        if (fires != 1) $display("FAIL lsb_0d_detect: got %0d want 1", fires); else passed++;
    endtask

    task automatic test_abort();
        din = 8'hFF; vm = 1'b1;
        tick();
        vm = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 3) begin abort = 1'b1; vm = 1'b1; din = 8'h5A; #1; end
            checks++;
            if (obs(0) !== expv(0)) $display("FAIL abort c%0d: got %b want %b", c, obs(0), expv(0));
            else passed++;
            if (c == 4) begin
                checks++;
                if ({x_m, xv_m, wd_m} !== 3'b000) $display("FAIL abort_flush: got %b want 000", {x_m, xv_m, wd_m});
                else passed++;
                abort = 1'b0; #1;
                checks++;
                if (rdy_m !== 1'b1) $display("FAIL abort_ready: got %b want 1", rdy_m); else passed++;
            end
            if (c == 5) begin
                checks++;
                if (xv_m !== 1'b1) $display("FAIL abort_reaccept: x_valid got %b want 1", xv_m); else passed++;
                vm = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] got = 8'h00;
        din = 8'hB2; vm = 1'b1;
        tick();
        vm = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (obs(0) !== expv(0)) $display("FAIL areset_pre c%0d: got %b want %b", c, obs(0), expv(0));
            else passed++;
            if (c < 6) tick();
        end
        #2 rst = 1'b0;
        #1;
        m_act[0] = 1'b0;
        checks++;
        if ({x_m, xv_m, wd_m} !== 3'b000) $display("FAIL areset_immediate: got %b want 000", {x_m, xv_m, wd_m});
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        tick();
        din = 8'hB2; vm = 1'b1;
        tick();
        vm = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            checks++;
            if (obs(0) !== expv(0)) $display("FAIL areset_post c%0d: got %b want %b", c, obs(0), expv(0));
            else passed++;
            if (c <= 8) got = {got[6:0], x_m};
            tick();
        end
        checks++;
        if (got !== 8'hB2) $display("FAIL areset_stream: got %h want b2", got); else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            vm    = ($urandom_range(0, 9) < 7);
            vl    = ($urandom_range(0, 9) < 7);
            din   = 8'($urandom);
            abort = ($urandom_range(0, 15) == 0);
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs(d) !== expv(d)) $display("FAIL random d%0d n%0d: got %b want %b", d, n, obs(d), expv(d));
                else passed++;
            end
            tick();
        end
        vm = 1'b0; vl = 1'b0; abort = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        test_reset();
        test_msb_word();
        test_back_to_back();
        test_lsb_word();
        test_abort();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
